// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - Op encoding (OP_MULT .. OP_MSUB) as issued by the ALU
//   - FSM state encoding (S_IDLE, S_RUN, S_FIX)
//   - small op-class helpers used by the top
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Ops whose operands are interpreted as two's complement.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the ALU-side issuer and muldiv_unit.
//   Start, Op, A, B      : issue request and operands (master -> slave)
//   Busy, Done, DivZero  : handshake/status (slave -> master)
//   Hi, Lo               : HI/LO result registers (slave -> master)
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, DivZero, Hi, Lo
  );
endinterface

// File: rtl/muldiv_divcore.sv
// muldiv_divcore: one restoring-division step (purely combinational).
//   rem_i : partial remainder (always < div_i)
//   quo_i : dividend bits still to be shifted in; quotient bits collect at LSB
//   div_i : divisor magnitude
//   rem_o, quo_o : state after shifting in one dividend bit and trial-subtracting
module muldiv_divcore #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] shifted;
  logic             ge;

  always_comb begin
    // The shifted remainder is WIDTH+1 bits wide; its top bit is rem_i[MSB].
    // If that bit is set the value already exceeds any WIDTH-bit divisor, and
    // because the result is < div_i the subtraction can be kept modulo 2^WIDTH.
    shifted = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
    ge      = rem_i[WIDTH-1] || (shifted >= div_i);
    if (ge) begin
      rem_o = shifted - div_i;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO result registers.
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-low reset
//   bus  : muldiv_if.slave -- Start/Op/A/B in; Busy/Done/DivZero/Hi/Lo out
// Iterative ops take WIDTH shift-add / restoring-divide steps on operand
// magnitudes, then one FIX cycle applies signs and writes Hi/Lo.
// Optional feature macro MULDIV_ACCUM_EN enables MADD/MSUB (Op 6/7); without
// it those opcodes are ignored entirely.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic     Clk,
  input logic     Rst,
  muldiv_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, divzero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Operand/iteration state: no reset needed, always loaded on accept.
  logic [WIDTH-1:0]   a_q, am_q, bm_q;
  logic [2:0]         op_q;
  logic               neg_q, rneg_q;
  logic [2*WIDTH-1:0] p_q;

  logic               in_signed, iter_op, start_run, div0;
  logic [WIDTH-1:0]   in_am, in_bm;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_o, quo_o;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [2*WIDTH-1:0] prod_s, res_hl;

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;

  always_comb begin
    iter_op = (bus.Op <= OP_DIVU);
`ifdef MULDIV_ACCUM_EN
    iter_op = iter_op || (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
`endif
    in_signed = op_is_signed(bus.Op);
    in_am     = (in_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    in_bm     = (in_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    start_run = (state_q == S_IDLE) && bus.Start && iter_op;
    div0      = op_is_div(op_q) && (bm_q == '0);
  end

  muldiv_divcore #(.WIDTH(WIDTH)) u_divcore (
    .rem_i (p_q[2*WIDTH-1:WIDTH]),
    .quo_i (p_q[WIDTH-1:0]),
    .div_i (bm_q),
    .rem_o (rem_o),
    .quo_o (quo_o)
  );

  // Shift-add multiply: multiplier sits in the low half and is consumed LSB
  // first while the partial product grows down from the high half.
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, am_q} : '0);

  always_comb begin
    prod_s = neg_q  ? -p_q : p_q;
    quo_s  = neg_q  ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    // Remainder follows the dividend's sign (truncating division).
    rem_s  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    res_hl = prod_s;
    if (div0) begin
      res_hl = {a_q, {WIDTH{1'b1}}};
    end else if (op_is_div(op_q)) begin
      res_hl = {rem_s, quo_s};
    end
`ifdef MULDIV_ACCUM_EN
    else if (op_q == OP_MADD) begin
      res_hl = {hi_q, lo_q} + prod_s;
    end else if (op_q == OP_MSUB) begin
      res_hl = {hi_q, lo_q} - prod_s;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (start_run) begin
      a_q    <= bus.A;
      am_q   <= in_am;
      bm_q   <= in_bm;
      op_q   <= bus.Op;
      neg_q  <= in_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      rneg_q <= in_signed && bus.A[WIDTH-1];
      p_q    <= {{WIDTH{1'b0}}, (op_is_div(bus.Op) ? in_am : in_bm)};
    end else if ((state_q == S_RUN) && !div0) begin
      p_q <= op_is_div(op_q) ? {rem_o, quo_o} : {mul_sum, p_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_run) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            divzero_q <= 1'b0;
          end else if (bus.Start && (bus.Op == OP_MTHI)) begin
            hi_q      <= bus.A;
            done_q    <= 1'b1;
            divzero_q <= 1'b0;
          end else if (bus.Start && (bus.Op == OP_MTLO)) begin
            lo_q      <= bus.A;
            done_q    <= 1'b1;
            divzero_q <= 1'b0;
          end
        end
        S_RUN: begin
          // A zero divisor needs no iterations: go straight to FIX.
          if (div0 || (cnt_q == LAST)) begin
            state_q <= S_FIX;
          end
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          {hi_q, lo_q} <= res_hl;
          divzero_q    <= div0;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit at WIDTH=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat, bcnt, dcnt;

  muldiv_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present Start for exactly one rising edge; returns in the cycle after it.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  // Counts cycles (and Busy cycles) until Done is seen, bounded at 100.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = 0;
    while (bus.Done !== 1'b1 && l < 100) begin
      if (bus.Busy === 1'b1) bc++;
      @(negedge Clk);
      l++;
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge Clk);
    check("rst_hi", bus.Hi, 64'h0);
    check("rst_lo", bus.Lo, 64'h0);
    check("rst_busy", bus.Busy, 64'h0);
    check("rst_done", bus.Done, 64'h0);
    check("rst_divzero", bus.DivZero, 64'h0);
    Rst = 1'b1;

    // MULT -3 * 7 = -21
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, bcnt);
    check("mult_latency", lat, 64'd33);
    check("mult_busy_cycles", bcnt, 64'd33);
    check("mult_busy_in_done", bus.Busy, 64'h0);
    check("mult_hi", bus.Hi, 64'hFFFFFFFF);
    check("mult_lo", bus.Lo, 64'hFFFFFFEB);
    @(negedge Clk);
    check("mult_done_pulse", bus.Done, 64'h0);

    // DIV by zero: early exit
    issue(OP_DIV, 32'd5, 32'd0);
    wait_done(lat, bcnt);
    check("div0_latency", lat, 64'd2);
    check("div0_hi", bus.Hi, 64'h5);
    check("div0_lo", bus.Lo, 64'hFFFFFFFF);
    check("div0_flag", bus.DivZero, 64'h1);

    // DIVU 100 / 7, also clears DivZero on accept
    issue(OP_DIVU, 32'd100, 32'd7);
    check("divzero_cleared", bus.DivZero, 64'h0);
    wait_done(lat, bcnt);
    check("divu_latency", lat, 64'd33);
    check("divu_lo", bus.Lo, 64'd14);
    check("divu_hi", bus.Hi, 64'd2);

    // DIV -100 / 7
    issue(OP_DIV, 32'hFFFFFF9C, 32'd7);
    wait_done(lat, bcnt);
    check("div_lo", bus.Lo, 64'hFFFFFFF2);
    check("div_hi", bus.Hi, 64'hFFFFFFFE);

    // DIV most-negative / -1 wraps
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bcnt);
    check("div_ovf_lo", bus.Lo, 64'h80000000);
    check("div_ovf_hi", bus.Hi, 64'h0);
    check("div_ovf_flag", bus.DivZero, 64'h0);

    // Start during Busy is ignored
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (3) @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = OP_MULTU;
    bus.A     = 32'd100;
    bus.B     = 32'd100;
    @(negedge Clk);
    bus.Start = 1'b0;
    wait_done(lat, bcnt);
    check("ignore_lo", bus.Lo, 64'd42);
    check("ignore_hi", bus.Hi, 64'h0);

    // Start in the Done cycle is accepted
    issue(OP_MULTU, 32'd5, 32'd5);
    wait_done(lat, bcnt);
    check("b2b_first_lo", bus.Lo, 64'd25);
    bus.Start = 1'b1;
    bus.Op    = OP_MULTU;
    bus.A     = 32'd3;
    bus.B     = 32'd3;
    @(negedge Clk);
    bus.Start = 1'b0;
    check("b2b_busy", bus.Busy, 64'h1);
    wait_done(lat, bcnt);
    check("b2b_latency", lat, 64'd33);
    check("b2b_second_lo", bus.Lo, 64'd9);

    // MTHI / MTLO
    issue(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", bus.Hi, 64'h1234);
    check("mthi_done", bus.Done, 64'h1);
    check("mthi_busy", bus.Busy, 64'h0);
    @(negedge Clk);
    check("mthi_done_pulse", bus.Done, 64'h0);
    issue(OP_MTLO, 32'h55, 32'd0);
    check("mtlo_lo", bus.Lo, 64'h55);

    // Reset during RUN aborts
    issue(OP_MULTU, 32'd7, 32'd9);
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("abort_hi", bus.Hi, 64'h0);
    check("abort_lo", bus.Lo, 64'h0);
    check("abort_busy", bus.Busy, 64'h0);
    @(negedge Clk);
    Rst  = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) dcnt++;
    end
    check("abort_no_done", dcnt, 64'd0);

    // Accumulate (or its absence)
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd10, 32'd0);
`ifdef MULDIV_ACCUM_EN
    issue(OP_MADD, 32'd2, 32'd3);
    wait_done(lat, bcnt);
    check("madd_latency", lat, 64'd33);
    check("madd_lo", bus.Lo, 64'd16);
    check("madd_hi", bus.Hi, 64'h0);
    issue(OP_MSUB, 32'd4, 32'd5);
    wait_done(lat, bcnt);
    check("msub_lo", bus.Lo, 64'hFFFFFFFC);
    check("msub_hi", bus.Hi, 64'hFFFFFFFF);
`else
    issue(OP_MADD, 32'd2, 32'd3);
    check("madd_off_busy", bus.Busy, 64'h0);
    check("madd_off_done", bus.Done, 64'h0);
    dcnt = 0;
    repeat (5) begin
      @(negedge Clk);
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) dcnt++;
    end
    check("madd_off_quiet", dcnt, 64'd0);
    check("madd_off_lo", bus.Lo, 64'd10);
    check("madd_off_hi", bus.Hi, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with integrated HI/LO result registers.
- Successor to the single-cycle HiLo path: parametrised operand width, start/busy/done handshake, signed and unsigned divide, and optional multiply-accumulate.
- Sits beside ALU32Bit. The ALU issues operations; the DatapathController stalls the PC on Busy; mfhi/mflo read Hi/Lo directly.

Parameters:
- WIDTH, 32: operand width, and width of each of Hi and Lo (minimum 4).
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived).

Ports:
- Clk  input  1  system clock; all state changes on rising edge
- Rst  input  1  asynchronous, active-low reset
- Start  input  1  request; accepted only when Busy=0
- Op  input  3  operation code, sampled with Start
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt)
- Busy  output  1  iteration in progress
- Done  output  1  one-cycle pulse; Hi/Lo hold new result
- DivZero  output  1  last divide had B=0; sticky until next accepted Start
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset (Rst=0, asynchronous): Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state IDLE, counter=0.
- Op encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.

States:
- IDLE
  - Start=1 with Op in 0-3: latch operands, go to RUN, Busy=1 from the next cycle.
  - Start=1 with Op 4/5: Hi<=A or Lo<=A at that edge; Done pulses the next cycle; no Busy.
- RUN
  - WIDTH iterations, one per cycle: shift-add multiply or restoring divide, using operand magnitudes.
  - Then go to FIX.
- FIX
  - One cycle: apply sign correction, write Hi/Lo, Done=1, Busy=0, go to IDLE.

Latency and handshake:
- Start accepted at edge t. Busy is high for cycles t+1 .. t+WIDTH+1.
- Done and the Hi/Lo update occur at edge t+WIDTH+1; Busy deasserts in the same cycle as Done.
- Start while Busy=1 is ignored; there is no queueing.
- Start may be accepted in the same cycle Done is high.

Arithmetic:
- MULT/MULTU: {Hi,Lo} = A*B, full 2*WIDTH-bit product. Signed product is negated when sign(A)^sign(B).
- DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of A.
  - Most-negative / -1: Lo = most-negative value (wraps), Hi = 0, no flag.
- Divide by zero: early exit; skip RUN and go to FIX at t+1.
  - Hi = A, Lo = all ones; DivZero = 1; Done at t+2.
- Hi/Lo change only on Done edges or MTHI/MTLO; they are otherwise stable during Busy.
- Rst asserted mid-operation aborts it: Hi/Lo = 0, no Done.

Optional Feature:
- MULDIV_ACCUM_EN defined:
  - Op 6 (MADD): {Hi,Lo} += signed A*B.
  - Op 7 (MSUB): {Hi,Lo} -= signed A*B.
  - Both use MULT latency; the accumulate is applied in FIX, modulo 2^(2*WIDTH).
- Not defined: Op 6/7 are ignored. Start is not accepted, and there is no Busy, no Done, and no state change.

Decomposition:
- Package muldiv_pkg holds:
  - the Op encoding localparams (OP_MULT..OP_MSUB);
  - the state encoding (S_IDLE, S_RUN, S_FIX).
- Sub-module muldiv_divcore: restoring-divider iteration step (combinational remainder/quotient shift-subtract), instantiated once.
- Multiply iteration and sign fix stay in the top.

Test Plan (WIDTH=32):
- MULT: A=-3, B=7 -> Done at t+33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for exactly 33 cycles.
- DIVU and DIV:
  - DIVU A=100, B=7 -> Lo=14, Hi=2.
  - DIV A=-100, B=7 -> Lo=-14 (0xFFFFFFF2), Hi=-2 (0xFFFFFFFE).
- DIV edge cases:
  - DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
  - DIV B=0 with A=5 -> Done at t+2, Hi=5, Lo=0xFFFFFFFF, DivZero=1.
  - Next accepted Start clears DivZero.
- Handshake: second Start during Busy with different operands -> ignored; result matches the first op.
  - Start in the Done cycle -> accepted; Busy stays high continuously.
- MTHI/MTLO and reset:
  - MTHI A=0x1234 -> Hi=0x1234 at that edge, Done pulses the next cycle.
  - Rst=0 during RUN of a MULTU -> Hi=Lo=0, Busy=0, no Done.
- MULDIV_ACCUM_EN:
  - Defined: Hi:Lo=0:10, then MADD A=2, B=3 -> Lo=16; then MSUB A=4, B=5 -> {Hi,Lo}=-4.
  - Not defined: Op 6 produces no Busy and no Done.
